pwm_medidor: RTL

PWM_MEDIDOR -- requirements
Module: pwm_medidor

---
 rtl/pwm_medidor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_medidor.sv
// PWM meter: synchronizes pwm_in, measures each rising-edge-to-rising-edge span, and
// divides its high time by its length to report an R-bit duty cycle, with stuck-input detection.
module pwm_medidor #(
  parameter int R  = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [R-1:0]  duty,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          valid,
  output logic          timeout,
  output logic          stuck_level,
  output logic          overrun
);

  localparam int            IW       = $clog2(R + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [R-1:0]  DUTY_MAX = '1;
  localparam logic [IW-1:0] ITERS    = IW'(R);

  typedef enum logic {IDLE, MEAS} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_q, hi_d;
  logic          frozen_q, frozen_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] div_per_q, div_per_d;
  logic [CW-1:0] div_high_q, div_high_d;
  logic [R-1:0]  quo_q, quo_d;
  logic [R-1:0]  duty_q, duty_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          stuck_q, stuck_d;
  logic          overrun_q, overrun_d;

  logic          rise;
  logic          tmo_hit;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hi_inc;
  logic [CW:0]   rem_shift;
  logic          q_bit;

  always_comb begin
    rise      = sync2_q & ~prev_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
    hi_inc    = (sync2_q && (hi_q != CNT_MAX)) ? hi_q + CW'(1) : hi_q;
    tmo_hit   = (cnt_q == CNT_MAX) && !frozen_q && !rise;
    // Remainder stays below the divisor, so one extra bit holds the shifted value.
    rem_shift = {rem_q, 1'b0};
    q_bit     = (rem_shift >= {1'b0, div_per_q});
  end

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
    sync1_d    = pwm_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    frozen_d   = frozen_q;
    busy_d     = busy_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    div_per_d  = div_per_q;
    div_high_d = div_high_q;
    quo_d      = quo_q;
    duty_d     = duty_q;
    high_d     = high_q;
    period_d   = period_q;
    timeout_d  = timeout_q;
    stuck_d    = stuck_q;
    valid_d    = 1'b0;
    overrun_d  = 1'b0;

    // Restoring divider: R shift/subtract steps, then one cycle to publish the result.
    if (busy_q) begin
      if (iter_q != '0) begin
        rem_d  = q_bit ? (rem_shift[CW-1:0] - div_per_q) : rem_shift[CW-1:0];
        quo_d  = R'({quo_q, q_bit});
        iter_d = iter_q - IW'(1);
      end else begin
        busy_d    = 1'b0;
        valid_d   = 1'b1;
        duty_d    = quo_q;
        high_d    = div_high_q;
        period_d  = div_per_q;
        timeout_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = MEAS;
          cnt_d    = CW'(1);
          hi_d     = CW'(1);
          frozen_d = 1'b0;
        end else if (!frozen_q) begin
          cnt_d = cnt_inc;
        end
      end
      MEAS: begin
        if (rise) begin
          cnt_d = CW'(1);
          hi_d  = CW'(1);
          if (busy_q) begin
            overrun_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            iter_d     = ITERS;
            rem_d      = hi_q;
            quo_d      = '0;
            div_per_d  = cnt_q;
            div_high_d = hi_q;
          end
        end else begin
          cnt_d = cnt_inc;
          hi_d  = hi_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // A saturated since-edge counter means the input is stuck; report its level as the duty.
    if (tmo_hit) begin
      state_d   = IDLE;
      frozen_d  = 1'b1;
      timeout_d = 1'b1;
      stuck_d   = sync2_q;
      duty_d    = sync2_q ? DUTY_MAX : '0;
      high_d    = '0;
      period_d  = '0;
      valid_d   = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      frozen_q   <= 1'b0;
      busy_q     <= 1'b0;
      iter_q     <= '0;
      rem_q      <= '0;
      div_per_q  <= '0;
      div_high_q <= '0;
      quo_q      <= '0;
      duty_q     <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      stuck_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      frozen_q   <= frozen_d;
      busy_q     <= busy_d;
      iter_q     <= iter_d;
      rem_q      <= rem_d;
      div_per_q  <= div_per_d;
      div_high_q <= div_high_d;
      quo_q      <= quo_d;
      duty_q     <= duty_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      stuck_q    <= stuck_d;
      overrun_q  <= overrun_d;
    end
  end

  assign duty        = duty_q;
  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;
  assign overrun     = overrun_q;

endmodule
